// File: rtl/uart_pkg.sv
// Shared UART types: the stored receive entry is a framing-error flag plus the byte.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic                   ferr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

  function automatic rx_entry_t pack_entry(input logic ferr, input logic [UART_DATA_W-1:0] data);
    rx_entry_t e;
    e.ferr = ferr;
    e.data = data;
    return e;
  endfunction

  function automatic logic [UART_DATA_W-1:0] entry_data(input rx_entry_t e);
    return e.data;
  endfunction

  function automatic logic entry_ferr(input rx_entry_t e);
    return e.ferr;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side strobe and host-side read port of the UART receive buffer.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  // Write side is a bare strobe (no backpressure): rx_data/rx_ferr qualify rx_ready.
  // Read side is valid/ready: an entry transfers on any edge where rd_valid & rd_ready;
  // rd_valid never drops without a transfer and rd_data/rd_ferr hold while rd_valid & !rd_ready.
  logic                   rx_ready;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_ferr;
  logic                   rd_valid;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_ferr;
  logic                   rd_ready;

  modport slave (
    input  rx_ready, rx_data, rx_ferr, rd_ready,
    output rd_valid, rd_data, rd_ferr
  );

  modport master (
    output rx_ready, rx_data, rx_ferr, rd_ready,
    input  rd_valid, rd_data, rd_ferr
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Entry storage: simple dual-port RAM, synchronous write, asynchronous read, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output rx_entry_t     rdata
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT FIFO with fill level, threshold interrupt and
// sticky overrun flag with a saturating dropped-byte count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int THRESH = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_fifo_if.slave bus,
  input  logic         overrun_clr,
  output logic [AW:0]  level,
  output logic         empty,
  output logic         full,
  output logic         thresh_irq,
  output logic         overrun,
  output logic [7:0]   drop_cnt
);

  localparam logic [AW:0] LVL_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_THRESH = (AW+1)'(THRESH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  rx_entry_t     head;

  assign empty      = (level == '0);
  assign full       = (level == LVL_DEPTH);
  assign thresh_irq = (level >= LVL_THRESH);

  assign pop  = bus.rd_valid & bus.rd_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push = bus.rx_ready & (~full | pop);
  assign drop = bus.rx_ready & full & ~pop;

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr),
    .wdata (pack_entry(bus.rx_ferr, bus.rx_data)),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = entry_data(head);
  assign bus.rd_ferr  = entry_ferr(head);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (overrun_clr)          drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (overrun_clr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill, overrun, saturation and reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       overrun_clr = 1'b0;
  logic [4:0] level;
  logic       empty, full, thresh_irq, overrun;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  uart_rx_fifo_if bus_if();

  uart_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .overrun_clr (overrun_clr),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .thresh_irq  (thresh_irq),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, rx, ferr, rdy;
    logic [7:0] d;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ferr;
    logic [4:0] e_level;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic r, rx, f, rdy, input logic [7:0] d,
                              input logic ev, input logic [7:0] ed, input logic ef,
                              input logic [4:0] el);
    vec_t v;
    v.rst = r; v.rx = rx; v.ferr = f; v.rdy = rdy; v.d = d;
    v.e_valid = ev; v.e_data = ed; v.e_ferr = ef; v.e_level = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs are applied 1ns after an edge and held for exactly one rising edge.
  task automatic cycle(input logic r, rx, f, rdy, clr, input logic [7:0] d);
    rst = r; bus_if.rx_ready = rx; bus_if.rx_data = d; bus_if.rx_ferr = f;
    bus_if.rd_ready = rdy; overrun_clr = clr;
    @(posedge clk); #1;
    rst = 1'b0; bus_if.rx_ready = 1'b0; bus_if.rd_ready = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic chk_lvl(input string tag, input int lv, input logic ov, input logic [7:0] dc);
    chk({tag, ".level"}, 32'(level), 32'(lv));
    chk({tag, ".empty"}, 32'(empty), 32'(lv == 0));
    chk({tag, ".full"}, 32'(full), 32'(lv == 16));
    chk({tag, ".thresh"}, 32'(thresh_irq), 32'(lv >= 8));
    chk({tag, ".valid"}, 32'(bus_if.rd_valid), 32'(lv != 0));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(dc));
  endtask

  task automatic pop_chk(input string tag);
    logic [8:0] e;
    chk({tag, ".valid"}, 32'(bus_if.rd_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".head"}, 32'({bus_if.rd_ferr, bus_if.rd_data}), 32'(e));
    end else begin
      chk({tag, ".model_nonempty"}, 32'd0, 32'd1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    bus_if.rx_ready = 1'b0; bus_if.rx_data = 8'h00; bus_if.rx_ferr = 1'b0; bus_if.rd_ready = 1'b0;

    // r  rx f  rdy d       valid data  ferr level
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 8'hA5, 1, 8'hA5, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 8'h3B, 1, 8'h3B, 0, 1);
    vecs[4]  = mk(0, 1, 1, 0, 8'h3C, 1, 8'h3B, 0, 2);
    vecs[5]  = mk(0, 1, 0, 1, 8'h3D, 1, 8'h3C, 1, 2);
    vecs[6]  = mk(0, 0, 0, 1, 8'h00, 1, 8'h3D, 0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    vecs[9]  = mk(0, 1, 0, 1, 8'h12, 1, 8'h12, 0, 1);
    vecs[10] = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].rst, vecs[i].rx, vecs[i].ferr, vecs[i].rdy, 1'b0, vecs[i].d);
      chk($sformatf("vec%0d.valid", i), 32'(bus_if.rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].e_level));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e_level == 0));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d.data", i), 32'(bus_if.rd_data), 32'(vecs[i].e_data));
        chk($sformatf("vec%0d.ferr", i), 32'(bus_if.rd_ferr), 32'(vecs[i].e_ferr));
      end
    end

    // Fill to full with 0x00..0x0F.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_lvl("rst2", 0, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      exp_q.push_back({1'b0, 8'(i)});
      chk_lvl($sformatf("fill%0d", i), i + 1, 1'b0, 8'd0);
    end

    // Drops while full, then clear, then drop colliding with clear.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
    chk_lvl("drop2", 16, 1'b1, 8'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk_lvl("clr", 16, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
    chk_lvl("drop_clr", 16, 1'b1, 8'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk_lvl("clr2", 16, 1'b0, 8'd0);

    // Full with simultaneous pop and push: accepted, no overrun.
    chk("fullpp.head", 32'(bus_if.rd_data), 32'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    void'(exp_q.pop_front());
    exp_q.push_back({1'b0, 8'h77});
    chk_lvl("fullpp", 16, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain%0d", i));
    chk_lvl("drained", 0, 1'b0, 8'd0);

    // Saturating drop counter, then reset mid-stream.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
      exp_q.push_back({1'b0, 8'(8'h80 + i)});
    end
    for (int k = 1; k <= 300; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(k));
      if (k == 254) chk("sat254", 32'(drop_cnt), 32'd254);
      if (k == 255) chk("sat255", 32'(drop_cnt), 32'd255);
    end
    chk_lvl("sat300", 16, 1'b1, 8'd255);
    pop_chk("after_sat");
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
    exp_q.delete();
    chk_lvl("rst_mid", 0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
    exp_q.push_back({1'b0, 8'h12});
    chk_lvl("post_rst", 1, 1'b0, 8'd0);
    pop_chk("post_rst_rd");
    chk_lvl("final", 0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
